osd_info_writer: RTL and testbench

Core-side command generator for the OSD overlay in the `clk_sys` domain. On request, it streams a bitmap from a local source RAM into the OSD pixel buffer, one 256-byte page per write transaction. It then issues the info-box enable command with position, size and rotation, or the plain disable command. It drives the OSD's `io_osd`/`io_strobe`/`io_din` command bus directly, so a core can show status boxes without HPS involvement.

---
 rtl/osd_pkg.sv | 44 ++++
 rtl/osd_bus_tx.sv | 62 ++++++
 rtl/osd_info_writer.sv | 180 ++++++++++++++++++
 tb/tb_osd_info_writer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared constants and state types for the OSD command generator.
package osd_pkg;

    localparam logic [7:0] OSD_CMD_WRITE  = 8'h20;
    localparam logic [7:0] OSD_CMD_ENABLE = 8'h40;
    localparam logic [7:0] OSD_CMD_INFO   = 8'h45;

    localparam int OSD_PAGES    = 16;
    localparam int OSD_MAX_WCHR = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_CMD,
        ST_RD,
        ST_STB,
        ST_DRAIN,
        ST_END
    } osd_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_HIGH,
        TX_LOW
    } tx_state_t;

    typedef enum logic [1:0] {
        KIND_WRITE,
        KIND_INFO,
        KIND_HIDE
    } txn_kind_t;

    // Zero is promoted to one so every box has at least one cell.
    function automatic logic [5:0] clamp_size(input logic [5:0] v, input logic [5:0] max_v);
        if (v == 6'd0)
            return 6'd1;
        else if (v > max_v)
            return max_v;
        else
            return v;
    endfunction

endpackage

// File: rtl/osd_bus_tx.sv
// Serialises one 16-bit word onto the OSD strobe bus: setup, strobe high, strobe low.
module osd_bus_tx #(
    parameter int STROBE_CYC = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        word_valid,
    input  logic [15:0] word,
    output logic        word_ready,
    output logic        io_strobe,
    output logic [15:0] io_din
);
    import osd_pkg::*;

    localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

    tx_state_t       state_q;
    tx_state_t       state_d;
    logic [CW-1:0]   cnt_q;
    logic            cnt_last;

    assign cnt_last = (cnt_q == CW'(STROBE_CYC - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            state_q <= TX_IDLE;
        else
            state_q <= state_d;
    end

    // A new word may be accepted in the last low cycle, keeping back-to-back words gapless.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (word_valid) state_d = TX_SETUP;
            TX_SETUP: state_d = TX_HIGH;
            TX_HIGH:  if (cnt_last) state_d = TX_LOW;
            TX_LOW:   if (cnt_last) state_d = word_valid ? TX_SETUP : TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        word_ready = (state_q == TX_IDLE) || ((state_q == TX_LOW) && cnt_last);
        io_strobe  = (state_q == TX_HIGH);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            io_din <= '0;
        end else begin
            if (state_q != state_d)
                cnt_q <= '0;
            else if ((state_q == TX_HIGH) || (state_q == TX_LOW))
                cnt_q <= cnt_q + 1'b1;
            if (word_valid && word_ready)
                io_din <= word;
        end
    end

endmodule

// File: rtl/osd_info_writer.sv
// Streams a bitmap into the OSD page buffer, then enables the info box (or just disables the OSD).
module osd_info_writer #(
    parameter int STROBE_CYC = 1,
    parameter int GAP_CYC    = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        show,
    input  logic        hide,
    input  logic [11:0] box_x,
    input  logic [11:0] box_y,
    input  logic [5:0]  box_w,
    input  logic [5:0]  box_h,
    input  logic [1:0]  box_rot,
    output logic [11:0] src_addr,
    input  logic [7:0]  src_data,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        busy,
    output logic        done
);
    import osd_pkg::*;

    osd_state_t  state_q;
    osd_state_t  state_d;
    txn_kind_t   kind_q;
    logic [3:0]  page_q;
    logic [7:0]  idx_q;
    logic [7:0]  gap_q;
    logic [11:0] x_q;
    logic [11:0] y_q;
    logic [5:0]  w_q;
    logic [5:0]  h_q;
    logic [1:0]  rot_q;

    logic        word_valid;
    logic [15:0] word;
    logic        word_ready;

    logic [8:0]  n_words;
    logic        has_data;
    logic        last_word;
    logic        gap_done;
    logic        last_page;
    logic        more_txn;
    logic [7:0]  cmd_byte;
    logic [15:0] param_word;
    logic [7:0]  col_rd;

    osd_bus_tx #(
        .STROBE_CYC (STROBE_CYC)
    ) u_bus_tx (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .word_valid (word_valid),
        .word       (word),
        .word_ready (word_ready),
        .io_strobe  (io_strobe),
        .io_din     (io_din)
    );

    always_comb begin
        case (kind_q)
            KIND_WRITE: n_words = {w_q, 3'b000};
            KIND_INFO:  n_words = 9'd5;
            default:    n_words = 9'd0;
        endcase
        has_data  = (n_words != 9'd0);
        last_word = ({1'b0, idx_q} == (n_words - 9'd1));
        gap_done  = (gap_q == 8'(GAP_CYC - 1));
        last_page = (page_q == 4'(h_q - 6'd1));
        more_txn  = (kind_q == KIND_WRITE);
        case (kind_q)
            KIND_WRITE: cmd_byte = OSD_CMD_WRITE | {4'h0, page_q};
            KIND_INFO:  cmd_byte = OSD_CMD_INFO;
            default:    cmd_byte = OSD_CMD_ENABLE;
        endcase
        case (idx_q[2:0])
            3'd0:    param_word = {4'h0, x_q};
            3'd1:    param_word = {4'h0, y_q};
            3'd2:    param_word = {10'h0, w_q};
            3'd3:    param_word = {10'h0, h_q};
            default: param_word = {14'h0, rot_q};
        endcase
        col_rd = (state_q == ST_STB) ? idx_q + 8'd1 : idx_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (hide || show) state_d = ST_GAP;
            ST_GAP:   if (gap_done && word_ready) state_d = ST_CMD;
            ST_CMD:   state_d = has_data ? ST_RD : ST_DRAIN;
            ST_RD:    state_d = ST_STB;
            ST_STB:   if (word_ready) state_d = last_word ? ST_DRAIN : ST_RD;
            ST_DRAIN: if (word_ready) state_d = ST_END;
            ST_END:   state_d = more_txn ? ST_GAP : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The command word is handed over in the last gap cycle so its setup coincides with io_osd rising.
    always_comb begin
        word_valid = 1'b0;
        word       = 16'h0000;
        io_osd     = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_GAP: begin
                word_valid = gap_done;
                word       = {8'h00, cmd_byte};
            end
            ST_CMD, ST_RD, ST_DRAIN: io_osd = 1'b1;
            ST_STB: begin
                io_osd     = 1'b1;
                word_valid = 1'b1;
                word       = (kind_q == KIND_WRITE) ? {8'h00, src_data} : param_word;
            end
            default: io_osd = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            kind_q   <= KIND_WRITE;
            page_q   <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            rot_q    <= '0;
            src_addr <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state_q == ST_END) && !more_txn;
            case (state_q)
                ST_IDLE: begin
                    if (hide || show) begin
                        x_q    <= box_x;
                        y_q    <= box_y;
                        w_q    <= clamp_size(box_w, 6'(OSD_MAX_WCHR));
                        h_q    <= clamp_size(box_h, 6'(OSD_PAGES));
                        rot_q  <= box_rot;
                        kind_q <= hide ? KIND_HIDE : KIND_WRITE;
                        page_q <= '0;
                        idx_q  <= '0;
                        gap_q  <= '0;
                    end
                end
                ST_GAP: gap_q <= gap_q + 8'd1;
                ST_STB: if (word_ready) idx_q <= idx_q + 8'd1;
                ST_END: begin
                    gap_q <= '0;
                    idx_q <= '0;
                    if (kind_q == KIND_WRITE) begin
                        if (last_page)
                            kind_q <= KIND_INFO;
                        else
                            page_q <= page_q + 4'd1;
                    end
                end
                default: ;
            endcase
            // Address is registered on entry to RD so the source byte is ready in STB.
            if ((state_d == ST_RD) && (kind_q == KIND_WRITE))
                src_addr <= {page_q, col_rd};
        end
    end

endmodule

// File: tb/tb_osd_info_writer.sv
// Scoreboard bench: expected OSD words are queued per request and popped by a strobe monitor.
module tb_osd_info_writer;

    localparam int STROBE_CYC = 1;
    localparam int GAP_CYC    = 2;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        show    = 1'b0;
    logic        hide    = 1'b0;
    logic [11:0] box_x   = '0;
    logic [11:0] box_y   = '0;
    logic [5:0]  box_w   = '0;
    logic [5:0]  box_h   = '0;
    logic [1:0]  box_rot = '0;
    logic [11:0] src_addr;
    logic [7:0]  src_data;
    logic        io_osd;
    logic        io_strobe;
    logic [15:0] io_din;
    logic        busy;
    logic        done;

    logic [7:0]  mem [4096];
    logic [16:0] exp_q [$];
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          windows = 0;

    osd_info_writer #(
        .STROBE_CYC (STROBE_CYC),
        .GAP_CYC    (GAP_CYC)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .show      (show),
        .hide      (hide),
        .box_x     (box_x),
        .box_y     (box_y),
        .box_w     (box_w),
        .box_h     (box_h),
        .box_rot   (box_rot),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .io_osd    (io_osd),
        .io_strobe (io_strobe),
        .io_din    (io_din),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(posedge clk_sys) src_data <= mem[src_addr];

    initial begin
        #600000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=0x%0h required=none", name, act);
    endtask

    // Reference model: whole transaction list derived from the request arguments and source memory.
    task automatic push_expected(input bit is_hide, input logic [11:0] x, input logic [11:0] y,
                                 input int w, input int h, input int rot, output int nwin);
        int wc;
        int hc;
        if (is_hide) begin
            exp_q.push_back({1'b1, 16'h0040});
            nwin = 1;
            return;
        end
        wc = (w == 0) ? 1 : ((w > 32) ? 32 : w);
        hc = (h == 0) ? 1 : ((h > 16) ? 16 : h);
        for (int p = 0; p < hc; p++) begin
            exp_q.push_back({1'b1, 16'(32 + p)});
            for (int c = 0; c < wc * 8; c++)
                exp_q.push_back({1'b0, 8'h00, mem[p * 256 + c]});
        end
        exp_q.push_back({1'b1, 16'h0045});
        exp_q.push_back({1'b0, 4'h0, x});
        exp_q.push_back({1'b0, 4'h0, y});
        exp_q.push_back({1'b0, 16'(wc)});
        exp_q.push_back({1'b0, 16'(hc)});
        exp_q.push_back({1'b0, 16'(rot)});
        nwin = hc + 1;
    endtask

    task automatic apply_stimulus(input bit s, input bit hd, input logic [11:0] x, input logic [11:0] y,
                                  input logic [5:0] w, input logic [5:0] h, input logic [1:0] rot,
                                  output int nwin);
        @(negedge clk_sys);
        show    = s;
        hide    = hd;
        box_x   = x;
        box_y   = y;
        box_w   = w;
        box_h   = h;
        box_rot = rot;
        push_expected(hd, x, y, int'(w), int'(h), int'(rot), nwin);
        @(negedge clk_sys);
        show    = 1'b0;
        hide    = 1'b0;
        box_x   = 12'($urandom);
        box_y   = 12'($urandom);
        box_w   = 6'($urandom);
        box_h   = 6'($urandom);
        box_rot = 2'($urandom);
        check("busy_rise", 32'(busy), 1);
    endtask

    task automatic check_output(input string name, input int win0, input int exp_win, input int exp_lat);
        int n;
        n = 1;
        while (!done && n < 20000) begin
            @(negedge clk_sys);
            n++;
        end
        if (!done) begin
            fail_now({name, "_done_timeout"}, 32'(n));
        end else begin
            if (exp_lat > 0)
                check({name, "_latency"}, 32'(n), 32'(exp_lat));
            check({name, "_busy_at_done"}, 32'(busy), 0);
        end
        @(negedge clk_sys);
        check({name, "_done_pulse"}, 32'(done), 0);
        repeat (4) @(negedge clk_sys);
        check({name, "_windows"}, 32'(windows - win0), 32'(exp_win));
        check({name, "_words_left"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic monitor();
        logic        prev_s = 1'b0;
        logic        prev_o = 1'b0;
        logic        first  = 1'b0;
        logic [15:0] held   = '0;
        logic [16:0] e;
        int          last_rise = 0;
        int          last_fall = -100;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                prev_s = 1'b0;
                prev_o = 1'b0;
                continue;
            end
            if (io_osd && !prev_o) begin
                windows++;
                first = 1'b1;
                check("osd_gap", 32'(cyc - last_fall >= GAP_CYC), 1);
            end
            if (!io_osd && prev_o)
                last_fall = cyc;
            if (io_strobe && !prev_s) begin
                check("strobe_in_window", 32'(io_osd), 1);
                if (!first)
                    check("word_period", 32'(cyc - last_rise), 32'(2 * STROBE_CYC + 1));
                last_rise = cyc;
                held      = io_din;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_word", 32'(io_din));
                end else begin
                    e = exp_q.pop_front();
                    check("word", 32'({first, io_din}), 32'(e));
                end
                first = 1'b0;
            end
            if (!io_strobe && prev_s)
                check("din_hold", 32'(io_din), 32'(held));
            prev_s = io_strobe;
            prev_o = io_osd;
        end
    endtask

    initial begin
        int nwin;
        int win0;
        int stray;
        int guard;
        int k;

        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        fork
            monitor();
        join_none

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("reset_outputs", 32'({io_osd, io_strobe, io_din, src_addr, busy, done}), 0);
        reset_n = 1'b1;
        stray = 0;
        repeat (100) begin
            @(negedge clk_sys);
            if (io_strobe || io_osd || busy || done) stray++;
        end
        check("idle_after_reset", 32'(stray), 0);
        check("idle_windows", 32'(windows), 0);

        $display("[TB] hide");
        win0 = windows;
        apply_stimulus(1'b0, 1'b1, 12'd7, 12'd9, 6'd3, 6'd3, 2'd1, nwin);
        check_output("hide", win0, nwin, 7);

        $display("[TB] show 1x1");
        win0 = windows;
        apply_stimulus(1'b1, 1'b0, 12'd100, 12'd50, 6'd1, 6'd1, 2'd0, nwin);
        check_output("show_1x1", win0, nwin, -1);

        $display("[TB] show 4x16");
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        win0 = windows;
        apply_stimulus(1'b1, 1'b0, 12'hABC, 12'h123, 6'd4, 6'd16, 2'd3, nwin);
        check_output("show_4x16", win0, nwin, -1);

        $display("[TB] clamp");
        win0 = windows;
        apply_stimulus(1'b1, 1'b0, 12'd1, 12'd2, 6'd0, 6'd40, 2'd2, nwin);
        check_output("clamp", win0, nwin, -1);

        $display("[TB] collision");
        win0 = windows;
        apply_stimulus(1'b1, 1'b1, 12'd5, 12'd6, 6'd2, 6'd2, 2'd1, nwin);
        check_output("collision", win0, nwin, 7);

        $display("[TB] busy drop");
        win0 = windows;
        apply_stimulus(1'b1, 1'b0, 12'd300, 12'd200, 6'd2, 6'd6, 2'd1, nwin);
        guard = 0;
        while (!(io_strobe && io_din == 16'h0023) && guard < 5000) begin
            @(negedge clk_sys);
            guard++;
        end
        if (guard >= 5000) fail_now("page3_timeout", 32'(guard));
        show  = 1'b1;
        box_w = 6'd1;
        box_h = 6'd1;
        @(negedge clk_sys);
        show  = 1'b0;
        check_output("busy_drop", win0, nwin, -1);

        $display("[TB] random");
        for (int r = 0; r < 6; r++) begin
            bit hd;
            for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
            hd   = ($urandom_range(0, 3) == 0);
            win0 = windows;
            apply_stimulus(~hd, hd, 12'($urandom), 12'($urandom), 6'($urandom_range(0, 40)),
                           6'($urandom_range(0, 4)), 2'($urandom), nwin);
            check_output("random", win0, nwin, hd ? 7 : -1);
        end

        $display("[TB] reset mid-op");
        apply_stimulus(1'b1, 1'b0, 12'd1, 12'd1, 6'd4, 6'd4, 2'd0, nwin);
        k = 0;
        guard = 0;
        while (k < 20 && guard < 5000) begin
            @(negedge clk_sys);
            guard++;
            if (io_strobe) k++;
        end
        check("strobe_before_reset", 32'(io_strobe), 1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_osd", 32'(io_osd), 0);
        check("reset_mid_strobe", 32'(io_strobe), 0);
        check("reset_mid_busy", 32'(busy), 0);
        check("reset_mid_din", 32'(io_din), 0);
        exp_q.delete();
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);

        win0 = windows;
        apply_stimulus(1'b0, 1'b1, 12'd0, 12'd0, 6'd1, 6'd1, 2'd0, nwin);
        check_output("hide_after_reset", win0, nwin, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
